icache_prefetch_ctrl: RTL
=========================

Name: icache_prefetch_ctrl

Overview:
- Parametrised instruction-cache fill controller between the fetch stage, the icache array and the tagged memory bus.
- On a fetch miss it redirects the request stream to the missing line, then prefetches sequential lines up to a bounded window ahead of the fetch address.
- Outstanding requests are tracked in a tag-indexed MSHR file. Duplicate requests are suppressed.
- A flush input discards in-flight fills so they never reach the cache.

Parameters:
ADDR_W, 64, address width in bits
DATA_W, 64, line/bus data width in bits
TAG_W, 4, memory tag width; tag 0 means "no response / no data"; MSHR has 2^TAG_W entries (entry 0 unused)
LINE_BYTES, 8, bytes per line; power of two
PF_DEPTH, 4, lines allowed ahead of the current fetch line, including it
MAX_OUTSTANDING, 8, cap on valid MSHR entries; must be at most 2^TAG_W-1

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
proc2ctr_rd_addr  in  ADDR_W  fetch address
proc2ctr_flush  in  1  discard in-flight fills, restart at fetch line
cache2ctr_rd_data  in  DATA_W  cache read data
cache2ctr_rd_valid  in  1  cache hit
mem2ctr_response  in  TAG_W  nonzero = request accepted, with this tag
mem2ctr_tag  in  TAG_W  nonzero = data returning for this tag
mem2ctr_wr_data  in  DATA_W  returning data
ctr2proc_rd_data  out  DATA_W  equals cache2ctr_rd_data
ctr2proc_rd_valid  out  1  equals cache2ctr_rd_valid
ctr2cache_rd_addr  out  ADDR_W  equals proc2ctr_rd_addr
ctr2cache_wr_addr  out  ADDR_W  fill line address
ctr2cache_wr_data  out  DATA_W  equals mem2ctr_wr_data
ctr2cache_wr_enable  out  1  fill write strobe
ctr2mem_req_addr  out  ADDR_W  request address
ctr2mem_command  out  2  BUS_NONE or BUS_LOAD
ctr2proc_outstanding  out  TAG_W+1  count of valid MSHR entries

Behaviour:
- Definitions:
  - line(a) = a with the low log2(LINE_BYTES) bits cleared.
  - fl = line(proc2ctr_rd_addr).
  - All address arithmetic is modulo 2^ADDR_W.
- State:
  - req_ptr, ADDR_W bits.
  - mshr_addr[], mshr_valid[] and mshr_stale[], one entry per tag.
- Reset (reset low, asynchronous):
  - req_ptr=0; all valid and stale bits cleared.
  - ctr2mem_command=BUS_NONE, ctr2cache_wr_enable=0, ctr2proc_outstanding=0.
- Redirect (combinational): asserted when cache2ctr_rd_valid=0 and (req_ptr-fl) >= PF_DEPTH*LINE_BYTES (unsigned).
  - issue_addr = redirect ? fl : req_ptr.
- Issue: ctr2mem_command=BUS_LOAD only when all of the following hold:
  - no flush this cycle;
  - (issue_addr-fl) < PF_DEPTH*LINE_BYTES (unsigned, so window wrap is handled);
  - outstanding < MAX_OUTSTANDING;
  - no valid, non-stale MSHR entry holds issue_addr.
  - Otherwise BUS_NONE.
  - ctr2mem_req_addr = issue_addr at all times.
- Pointer update (registered):
  - flush: req_ptr <= fl.
  - LOAD and response != 0: req_ptr <= issue_addr+LINE_BYTES.
  - duplicate hit (only reason for BUS_NONE): req_ptr <= issue_addr+LINE_BYTES.
  - otherwise: req_ptr <= issue_addr, so a redirect is held.
- Allocate: on LOAD with response=t != 0: mshr_addr[t] <= issue_addr, valid[t] <= 1, stale[t] <= 0.
  - response != 0 while command is BUS_NONE is ignored.
- Return: on mem2ctr_tag=t != 0 with valid[t]=1, clear valid[t].
  - ctr2cache_wr_enable = valid[t] & !stale[t], combinational in the same cycle; ctr2cache_wr_addr = mshr_addr[t].
  - Return on an invalid tag: no write, no state change.
- Same tag accepted and returned in one cycle: the return is processed first using the old entry; the entry then holds the new address, valid=1, stale=0.
- Flush: every currently valid entry gets stale=1. A return in the same cycle is still written if it was not already stale.
- Latency:
  - Miss to request: 0 cycles (combinational redirect).
  - Return to cache write: 0 cycles.
  - Sequential prefetch: one line per accepted cycle.
- ctr2proc_outstanding = popcount(mshr_valid), registered.

Test Plan:
- Reset low mid-run with 3 entries valid -> outstanding=0, command=BUS_NONE immediately; after release req_ptr=0.
- Fetch 0x1000 misses, bus accepts every cycle with tags 1,2,3,4 -> requests 0x1000, 0x1008, 0x1010, 0x1018; fifth cycle BUS_NONE (window full); fetch advances to 0x1008 -> request 0x1020.
- Miss at 0x2000 while req_ptr=0x1020 -> same-cycle request 0x2000; mem2ctr_tag returns tag 1 -> wr_enable=1, wr_addr=0x1000, entry freed.
- Bus holds response=0 for 3 cycles -> req_addr stays 0x1000 with BUS_LOAD held; accept with tag 5 -> mshr[5]=0x1000.
- Flush with tags 2,3 outstanding, then returns on 2 and 3 -> wr_enable=0 on both; outstanding goes 2->1->0; next request is at the fetch line.
- MAX_OUTSTANDING=2, PF_DEPTH=4, no returns -> exactly 2 requests, then BUS_NONE; one return -> one new request next cycle. Fetch at 0xFFFF_FFFF_FFFF_FFF8 -> requests wrap to 0x0, 0x8.

Source files
------------

// File: rtl/icache_prefetch_ctrl_if.sv
// Bundle of fetch-side, cache-side and memory-bus signals around the icache fill controller.
// The master modport is the controller's view and the slave modport is the environment's view.
interface icache_prefetch_ctrl_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
);
    logic [ADDR_W-1:0] proc2ctr_rd_addr;
    logic              proc2ctr_flush;
    logic [DATA_W-1:0] cache2ctr_rd_data;
    logic              cache2ctr_rd_valid;
    logic [TAG_W-1:0]  mem2ctr_response;
    logic [TAG_W-1:0]  mem2ctr_tag;
    logic [DATA_W-1:0] mem2ctr_wr_data;
    logic [DATA_W-1:0] ctr2proc_rd_data;
    logic              ctr2proc_rd_valid;
    logic [ADDR_W-1:0] ctr2cache_rd_addr;
    logic [ADDR_W-1:0] ctr2cache_wr_addr;
    logic [DATA_W-1:0] ctr2cache_wr_data;
    logic              ctr2cache_wr_enable;
    logic [ADDR_W-1:0] ctr2mem_req_addr;
    logic [1:0]        ctr2mem_command;
    logic [TAG_W:0]    ctr2proc_outstanding;

    modport master (
        input  proc2ctr_rd_addr, proc2ctr_flush, cache2ctr_rd_data, cache2ctr_rd_valid,
               mem2ctr_response, mem2ctr_tag, mem2ctr_wr_data,
        output ctr2proc_rd_data, ctr2proc_rd_valid, ctr2cache_rd_addr, ctr2cache_wr_addr,
               ctr2cache_wr_data, ctr2cache_wr_enable, ctr2mem_req_addr, ctr2mem_command,
               ctr2proc_outstanding
    );

    modport slave (
        output proc2ctr_rd_addr, proc2ctr_flush, cache2ctr_rd_data, cache2ctr_rd_valid,
               mem2ctr_response, mem2ctr_tag, mem2ctr_wr_data,
        input  ctr2proc_rd_data, ctr2proc_rd_valid, ctr2cache_rd_addr, ctr2cache_wr_addr,
               ctr2cache_wr_data, ctr2cache_wr_enable, ctr2mem_req_addr, ctr2mem_command,
               ctr2proc_outstanding
    );
endinterface

// File: rtl/icache_prefetch_ctrl.sv
// Icache fill controller: redirects on a fetch miss, prefetches sequential lines inside a
// bounded window, tracks outstanding fills per bus tag and drops fills made stale by a flush.
module icache_prefetch_ctrl #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int TAG_W           = 4,
    parameter int LINE_BYTES      = 8,
    parameter int PF_DEPTH        = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input logic                  clock,
    input logic                  reset,
    icache_prefetch_ctrl_if.master bus
);
    localparam int                NUM_TAGS  = 1 << TAG_W;
    localparam logic [1:0]        BUS_NONE  = 2'd0;
    localparam logic [1:0]        BUS_LOAD  = 2'd1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(LINE_BYTES);
    localparam logic [ADDR_W-1:0] WINDOW    = ADDR_W'(PF_DEPTH * LINE_BYTES);
    localparam logic [TAG_W:0]    MAX_OUT_C = (TAG_W + 1)'(MAX_OUTSTANDING);

    logic [ADDR_W-1:0]   req_ptr_r;
    logic [ADDR_W-1:0]   mshr_addr_r [NUM_TAGS];
    logic [NUM_TAGS-1:0] mshr_valid_r;
    logic [NUM_TAGS-1:0] mshr_stale_r;
    logic [TAG_W:0]      outstanding_r;

    logic [ADDR_W-1:0]   fl_s;
    logic [ADDR_W-1:0]   issue_addr_s;
    logic [ADDR_W-1:0]   ptr_nxt_s;
    logic                redirect_s;
    logic                in_window_s;
    logic                room_s;
    logic                dup_s;
    logic                load_s;
    logic                accept_s;
    logic                ret_hit_s;
    logic                wr_en_s;
    logic [NUM_TAGS-1:0] valid_nxt_s;
    logic [NUM_TAGS-1:0] stale_nxt_s;

    function automatic logic [TAG_W:0] popcount(input logic [NUM_TAGS-1:0] v);
        logic [TAG_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            c = c + {{TAG_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Request selection: redirect target, window/capacity/duplicate gating and return lookup
    always_comb begin
        fl_s         = bus.proc2ctr_rd_addr & LINE_MASK;
        redirect_s   = ~bus.cache2ctr_rd_valid && ((req_ptr_r - fl_s) >= WINDOW);
        issue_addr_s = redirect_s ? fl_s : req_ptr_r;
        // Unsigned difference keeps the window test correct across address wrap
        in_window_s  = (issue_addr_s - fl_s) < WINDOW;
        room_s       = outstanding_r < MAX_OUT_C;
        dup_s        = 1'b0;
        for (int i = 1; i < NUM_TAGS; i++) begin
            dup_s = dup_s | (mshr_valid_r[i] & ~mshr_stale_r[i] & (mshr_addr_r[i] == issue_addr_s));
        end
        load_s    = reset && ~bus.proc2ctr_flush && in_window_s && room_s && ~dup_s;
        accept_s  = load_s && (bus.mem2ctr_response != {TAG_W{1'b0}});
        ret_hit_s = (bus.mem2ctr_tag != {TAG_W{1'b0}}) && mshr_valid_r[bus.mem2ctr_tag];
        wr_en_s   = ret_hit_s && ~mshr_stale_r[bus.mem2ctr_tag];
    end

    // Next MSHR flags and request pointer; a return frees its entry before a same-tag allocate
    always_comb begin
        valid_nxt_s = '0;
        stale_nxt_s = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            valid_nxt_s[i] = (mshr_valid_r[i] & ~(ret_hit_s && (bus.mem2ctr_tag == TAG_W'(i))))
                           | (accept_s && (bus.mem2ctr_response == TAG_W'(i)));
            stale_nxt_s[i] = (mshr_stale_r[i] | (bus.proc2ctr_flush & mshr_valid_r[i]))
                           & ~(accept_s && (bus.mem2ctr_response == TAG_W'(i)));
        end
        if (bus.proc2ctr_flush) begin
            ptr_nxt_s = fl_s;
        end else if (accept_s || (in_window_s && room_s && dup_s)) begin
            ptr_nxt_s = issue_addr_s + STEP;
        end else begin
            ptr_nxt_s = issue_addr_s;
        end
    end

    // Pointer, MSHR flags and outstanding count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_ptr_r     <= '0;
            mshr_valid_r  <= '0;
            mshr_stale_r  <= '0;
            outstanding_r <= '0;
        end else begin
            req_ptr_r     <= ptr_nxt_s;
            mshr_valid_r  <= valid_nxt_s;
            mshr_stale_r  <= stale_nxt_s;
            outstanding_r <= popcount(valid_nxt_s);
        end
    end

    // MSHR line addresses, written on an accepted request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                mshr_addr_r[i] <= '0;
            end
        end else if (accept_s) begin
            mshr_addr_r[bus.mem2ctr_response] <= issue_addr_s;
        end
    end

    assign bus.ctr2proc_rd_data     = bus.cache2ctr_rd_data;
    assign bus.ctr2proc_rd_valid    = bus.cache2ctr_rd_valid;
    assign bus.ctr2cache_rd_addr    = bus.proc2ctr_rd_addr;
    assign bus.ctr2cache_wr_data    = bus.mem2ctr_wr_data;
    assign bus.ctr2cache_wr_addr    = mshr_addr_r[bus.mem2ctr_tag];
    assign bus.ctr2cache_wr_enable  = wr_en_s;
    assign bus.ctr2mem_req_addr     = issue_addr_s;
    assign bus.ctr2mem_command      = load_s ? BUS_LOAD : BUS_NONE;
    assign bus.ctr2proc_outstanding = outstanding_r;
endmodule
